// File: rtl/game_pkg.sv
// Shared types and board constants for the shot responder.
package game_pkg;

    localparam int GRID_N      = 10;
    localparam int FLEET_CELLS = 20;
    localparam int MAP_CELLS   = GRID_N * GRID_N;

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
    } coord_t;

    typedef enum logic [2:0] {
        PLACE,
        READY,
        EVAL,
        REPLY,
        DEAD
    } resp_state_t;

    function automatic logic in_range(coord_t c);
        return (int'(c.row) < GRID_N) && (int'(c.col) < GRID_N);
    endfunction

    // Only meaningful for in-range coordinates; callers gate on in_range().
    function automatic logic [6:0] cell_idx(coord_t c);
        int i;
        i = int'(c.row) * GRID_N + int'(c.col);
        return 7'(i);
    endfunction

endpackage

// File: rtl/shot_responder_if.sv
// Shot request / reply handshake between the link receiver and the responder.
interface shot_responder_if;
    import game_pkg::*;

    logic   shot_valid;
    coord_t shot_pos;
    logic   shot_ready;
    logic   reply_valid;
    logic   reply_ready;
    logic   reply_hit;
    logic   reply_dup;

    modport master (
        output shot_valid, shot_pos, reply_ready,
        input  shot_ready, reply_valid, reply_hit, reply_dup
    );

    modport slave (
        input  shot_valid, shot_pos, reply_ready,
        output shot_ready, reply_valid, reply_hit, reply_dup
    );

endinterface

// File: rtl/shot_responder_fleet_map.sv
// fleet_map: per-cell ship bits (and shot bits when SHOT_DUP_REJECT_EN is
// defined) with one shared address for the write port and combinational read.
module fleet_map
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] idx,
    input  logic       ship_we,
    input  logic       ship_val,
    output logic       ship_bit
`ifdef SHOT_DUP_REJECT_EN
    ,
    input  logic       shot_we,
    output logic       shot_bit
`endif
);

    logic             in_map;
    logic [MAP_CELLS-1:0] ship_q;

    assign in_map   = int'(idx) < MAP_CELLS;
    assign ship_bit = in_map ? ship_q[idx] : 1'b0;

    // Ship bit array: set during placement, optionally cleared on hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ship_q <= '0;
        else if (ship_we && in_map)
            ship_q[idx] <= ship_val;
    end

`ifdef SHOT_DUP_REJECT_EN
    logic [MAP_CELLS-1:0] shot_q;

    assign shot_bit = in_map ? shot_q[idx] : 1'b0;

    // Shot bit array: remembers every in-range cell the opponent has fired at.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            shot_q <= '0;
        else if (shot_we && in_map)
            shot_q[idx] <= 1'b1;
    end
`endif

endmodule

// File: rtl/shot_responder.sv
// shot_responder: resolves opponent shots against the local fleet map.
// Optional SHOT_DUP_REJECT_EN keeps a shot map and flags repeated shots.
//
// state | meaning
// PLACE | accepting ship cells until lock with a full fleet
// READY | waiting for an opponent shot
// EVAL  | resolving captured shot against the maps
// REPLY | answer presented, waiting for reply_ready
// DEAD  | every fleet cell hit; only reset leaves
module shot_responder
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       place_valid,
    input  coord_t     place_pos,
    input  logic       lock,
    shot_responder_if.slave bus,
    output logic       fleet_dead,
    output logic [6:0] cells_left,
    output logic [6:0] placed_cnt
);

    localparam logic [6:0] FC7 = 7'(FLEET_CELLS);

    resp_state_t state_q, state_d;
    coord_t      shot_q, shot_d;
    logic [6:0]  cells_q, cells_d;
    logic [6:0]  placed_q, placed_d;
    logic        hit_q, hit_d;
    logic        dup_q, dup_d;
    logic        shot_ready_q, reply_valid_q, fleet_dead_q;

    logic [6:0]  map_idx;
    logic        ship_we, ship_val, ship_bit;
`ifdef SHOT_DUP_REJECT_EN
    logic        shot_we, shot_bit;
`endif

    fleet_map u_map (
        .clk      (clk),
        .rst      (rst),
        .idx      (map_idx),
        .ship_we  (ship_we),
        .ship_val (ship_val),
        .ship_bit (ship_bit)
`ifdef SHOT_DUP_REJECT_EN
        ,
        .shot_we  (shot_we),
        .shot_bit (shot_bit)
`endif
    );

    // Next-state, counter and map-write decisions.
    always_comb begin
        state_d  = state_q;
        shot_d   = shot_q;
        cells_d  = cells_q;
        placed_d = placed_q;
        hit_d    = hit_q;
        dup_d    = dup_q;
        ship_we  = 1'b0;
        ship_val = 1'b1;
`ifdef SHOT_DUP_REJECT_EN
        shot_we  = 1'b0;
`endif
        map_idx  = (state_q == PLACE) ? cell_idx(place_pos) : cell_idx(shot_q);

        case (state_q)
            PLACE: begin
                if (place_valid && in_range(place_pos) && !ship_bit && (placed_q < FC7)) begin
                    ship_we  = 1'b1;
                    placed_d = placed_q + 7'd1;
                end
                if (lock && (placed_q == FC7)) begin
                    state_d = READY;
                    cells_d = FC7;
                end
            end
            READY: begin
                if (bus.shot_valid) begin
                    shot_d  = bus.shot_pos;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                hit_d   = 1'b0;
                dup_d   = 1'b0;
                state_d = REPLY;
                if (in_range(shot_q)) begin
`ifdef SHOT_DUP_REJECT_EN
                    if (shot_bit) begin
                        dup_d = 1'b1;
                        hit_d = ship_bit;
                    end else begin
                        shot_we = 1'b1;
                        if (ship_bit) begin
                            hit_d = 1'b1;
                            if (cells_q != 7'd0)
                                cells_d = cells_q - 7'd1;
                        end
                    end
`else
                    // Clearing the ship bit makes a repeat shot on it read as a miss.
                    if (ship_bit) begin
                        hit_d    = 1'b1;
                        ship_we  = 1'b1;
                        ship_val = 1'b0;
                        if (cells_q != 7'd0)
                            cells_d = cells_q - 7'd1;
                    end
`endif
                end
            end
            REPLY: begin
                if (bus.reply_ready)
                    state_d = (cells_q == 7'd0) ? DEAD : READY;
            end
            DEAD: begin
                state_d = DEAD;
            end
            default: begin
                state_d = PLACE;
            end
        endcase
    end

    // State, captured shot, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= PLACE;
            shot_q        <= '0;
            cells_q       <= '0;
            placed_q      <= '0;
            hit_q         <= 1'b0;
            dup_q         <= 1'b0;
            shot_ready_q  <= 1'b0;
            reply_valid_q <= 1'b0;
            fleet_dead_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            shot_q        <= shot_d;
            cells_q       <= cells_d;
            placed_q      <= placed_d;
            hit_q         <= hit_d;
            dup_q         <= dup_d;
            shot_ready_q  <= (state_d == READY);
            reply_valid_q <= (state_d == REPLY);
            fleet_dead_q  <= (state_d == DEAD);
        end
    end

    assign bus.shot_ready  = shot_ready_q;
    assign bus.reply_valid = reply_valid_q;
    assign bus.reply_hit   = hit_q;
    assign bus.reply_dup   = dup_q;
    assign fleet_dead      = fleet_dead_q;
    assign cells_left      = cells_q;
    assign placed_cnt      = placed_q;

endmodule

// File: tb/tb_shot_responder.sv
// Self-checking bench for shot_responder; honours SHOT_DUP_REJECT_EN.
module tb_shot_responder;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       place_valid;
    coord_t     place_pos;
    logic       lock;
    logic       fleet_dead;
    logic [6:0] cells_left;
    logic [6:0] placed_cnt;

    shot_responder_if bus();

    shot_responder dut (
        .clk         (clk),
        .rst         (rst),
        .place_valid (place_valid),
        .place_pos   (place_pos),
        .lock        (lock),
        .bus         (bus),
        .fleet_dead  (fleet_dead),
        .cells_left  (cells_left),
        .placed_cnt  (placed_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pos;
        logic       hit;
        logic       dup;
        logic [6:0] left;
    } vec_t;

    typedef struct {
        logic       hit;
        logic       dup;
        logic [6:0] left;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];
    logic [7:0] fleet[20] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h23, 8'h24, 8'h25,
                              8'h40, 8'h50, 8'h60, 8'h77, 8'h78, 8'h79,
                              8'h92, 8'h93, 8'h94, 8'h95, 8'h96, 8'h19, 8'h39};
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic place(input logic [7:0] p);
        place_valid = 1'b1;
        place_pos   = p;
        @(negedge clk);
        place_valid = 1'b0;
    endtask

    task automatic place_fleet();
        for (int i = 0; i < 20; i++) place(fleet[i]);
    endtask

    // Offers a shot, waits for acceptance, checks reply latency and pops the scoreboard.
    task automatic shot(input string name, input logic [7:0] p, input logic h,
                        input logic d, input logic [6:0] l);
        exp_t e;
        int   k;
        sb.push_back('{hit: h, dup: d, left: l});
        bus.shot_valid = 1'b1;
        bus.shot_pos   = p;
        k = 0;
        while (!bus.shot_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.shot_ready) begin
            timeout({name, "_accept"});
            bus.shot_valid = 1'b0;
            void'(sb.pop_back());
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.shot_valid  = 1'b0;
        bus.reply_ready = 1'b1;
        check({name, "_eval_valid"}, bus.reply_valid, 1'b0);
        @(negedge clk);
        check({name, "_reply_valid"}, bus.reply_valid, 1'b1);
        e = sb.pop_front();
        check({name, "_hit"}, bus.reply_hit, e.hit);
        check({name, "_dup"}, bus.reply_dup, e.dup);
        check({name, "_left"}, cells_left, e.left);
        @(negedge clk);
        bus.reply_ready = 1'b0;
        check({name, "_valid_drop"}, bus.reply_valid, 1'b0);
    endtask

    initial begin
        exp_t e;
        int   k;
        logic [6:0] left;

        vecs[0] = '{pos: 8'h23, hit: 1'b1, dup: 1'b0, left: 7'd19};
        vecs[1] = '{pos: 8'h55, hit: 1'b0, dup: 1'b0, left: 7'd19};
        vecs[2] = '{pos: 8'hA3, hit: 1'b0, dup: 1'b0, left: 7'd19};
`ifdef SHOT_DUP_REJECT_EN
        vecs[3] = '{pos: 8'h23, hit: 1'b1, dup: 1'b1, left: 7'd19};
`else
        vecs[3] = '{pos: 8'h23, hit: 1'b0, dup: 1'b0, left: 7'd19};
`endif
        vecs[4] = '{pos: 8'h3A, hit: 1'b0, dup: 1'b0, left: 7'd19};
        vecs[5] = '{pos: 8'h00, hit: 1'b1, dup: 1'b0, left: 7'd18};
        vecs[6] = '{pos: 8'h99, hit: 1'b0, dup: 1'b0, left: 7'd18};

        rst             = 1'b1;
        place_valid     = 1'b0;
        place_pos       = '0;
        lock            = 1'b0;
        bus.shot_valid  = 1'b0;
        bus.shot_pos    = '0;
        bus.reply_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_shot_ready", bus.shot_ready, 1'b0);
        check("rst_reply_valid", bus.reply_valid, 1'b0);
        check("rst_reply_hit", bus.reply_hit, 1'b0);
        check("rst_reply_dup", bus.reply_dup, 1'b0);
        check("rst_fleet_dead", fleet_dead, 1'b0);
        check("rst_cells_left", cells_left, 7'd0);
        check("rst_placed_cnt", placed_cnt, 7'd0);
        rst = 1'b0;
        @(negedge clk);

        // Placement: duplicates and out-of-range writes are ignored.
        place(fleet[0]);
        check("place_first_cnt", placed_cnt, 7'd1);
        place(8'h00);
        place(8'hA0);
        place(8'h0A);
        check("place_dup_oor_cnt", placed_cnt, 7'd1);
        for (int i = 1; i < 19; i++) place(fleet[i]);
        check("place_19_cnt", placed_cnt, 7'd19);
        lock = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("lock_short_ready", bus.shot_ready, 1'b0);
        lock = 1'b0;
        place(fleet[19]);
        check("place_20_cnt", placed_cnt, 7'd20);
        place(8'h88);
        check("place_beyond_cnt", placed_cnt, 7'd20);
        lock = 1'b1;
        @(negedge clk);
        check("lock_ready", bus.shot_ready, 1'b1);
        check("lock_cells_left", cells_left, 7'd20);

        for (int i = 0; i < 7; i++)
            shot($sformatf("vec%0d", i), vecs[i].pos, vecs[i].hit, vecs[i].dup, vecs[i].left);

        // Stalled reply: outputs hold and a pending shot is not captured.
        sb.push_back('{hit: 1'b1, dup: 1'b0, left: 7'd17});
        bus.shot_valid = 1'b1;
        bus.shot_pos   = 8'h01;
        k = 0;
        while (!bus.shot_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.shot_ready) timeout("stall_accept");
        @(posedge clk);
        @(negedge clk);
        bus.shot_pos = 8'h55;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            check("stall_valid", bus.reply_valid, 1'b1);
            check("stall_hit", bus.reply_hit, 1'b1);
            check("stall_shot_ready", bus.shot_ready, 1'b0);
            @(negedge clk);
        end
        e = sb.pop_front();
        check("stall_pop_hit", bus.reply_hit, e.hit);
        check("stall_pop_left", cells_left, e.left);
        bus.shot_valid  = 1'b0;
        bus.reply_ready = 1'b1;
        @(negedge clk);
        bus.reply_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("stall_no_capture", bus.reply_valid, 1'b0);
        check("stall_ready_again", bus.shot_ready, 1'b1);
        check("stall_not_dead", fleet_dead, 1'b0);

        // Sink the rest of the fleet; 0x00, 0x01 and 0x23 are already hit.
        left = 7'd17;
        for (int i = 0; i < 20; i++) begin
            if (fleet[i] != 8'h00 && fleet[i] != 8'h01 && fleet[i] != 8'h23) begin
                left = left - 7'd1;
                shot($sformatf("sink_%0h", fleet[i]), fleet[i], 1'b1, 1'b0, left);
            end
        end
        check("dead_flag", fleet_dead, 1'b1);
        check("dead_shot_ready", bus.shot_ready, 1'b0);
        bus.shot_valid = 1'b1;
        bus.shot_pos   = 8'h55;
        for (int c = 0; c < 4; c++) @(negedge clk);
        check("dead_no_reply", bus.reply_valid, 1'b0);
        check("dead_sticky", fleet_dead, 1'b1);
        bus.shot_valid = 1'b0;

        // Reset while an answer is pending drops it.
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        lock = 1'b0;
        @(negedge clk);
        place_fleet();
        lock = 1'b1;
        @(negedge clk);
        sb.push_back('{hit: 1'b1, dup: 1'b0, left: 7'd19});
        bus.shot_valid = 1'b1;
        bus.shot_pos   = 8'h23;
        k = 0;
        while (!bus.shot_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.shot_ready) timeout("rst_mid_accept");
        @(posedge clk);
        @(negedge clk);
        bus.shot_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", bus.reply_valid, 1'b1);
        check("pre_rst_hit", bus.reply_hit, 1'b1);
        #2 rst = 1'b1;
        #1;
        sb.delete();
        check("mid_rst_valid", bus.reply_valid, 1'b0);
        check("mid_rst_hit", bus.reply_hit, 1'b0);
        check("mid_rst_dup", bus.reply_dup, 1'b0);
        check("mid_rst_shot_ready", bus.shot_ready, 1'b0);
        check("mid_rst_dead", fleet_dead, 1'b0);
        check("mid_rst_left", cells_left, 7'd0);
        check("mid_rst_placed", placed_cnt, 7'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_lock_ignored", bus.shot_ready, 1'b0);
        check("post_rst_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
